// File: rtl/seven_seg_pkg.sv
// Shared seven-segment encoding table (active-low, seg[0]=A .. seg[6]=G).
// Used by both the display driver and the bus reader so they agree on glyphs.
package seven_seg_pkg;

   typedef logic [0:6] seg_t;

   localparam seg_t SEG_0     = 7'h01;
   localparam seg_t SEG_1     = 7'h4F;
   localparam seg_t SEG_2     = 7'h12;
   localparam seg_t SEG_3     = 7'h06;
   localparam seg_t SEG_4     = 7'h4C;
   localparam seg_t SEG_5     = 7'h24;
   localparam seg_t SEG_6     = 7'h20;
   localparam seg_t SEG_7     = 7'h0F;
   localparam seg_t SEG_8     = 7'h00;
   localparam seg_t SEG_9     = 7'h04;
   localparam seg_t SEG_BLANK = 7'h7F;

   localparam logic [3:0] DIGIT_BLANK = 4'hF;
   localparam logic [3:0] DIGIT_ERR   = 4'hE;

endpackage

// File: rtl/seg_pattern_decode.sv
// Combinational segment-pattern to BCD decoder; anything outside the glyph
// table (other than all-off) is flagged as an error.
module seg_pattern_decode
   import seven_seg_pkg::*;
(
   input  seg_t       seg,
   output logic [3:0] digit,
   output logic       blank,
   output logic       err
);

   always_comb begin
      digit = DIGIT_ERR;
      blank = 1'b0;
      err   = 1'b0;
      case (seg)
         SEG_0:     digit = 4'd0;
         SEG_1:     digit = 4'd1;
         SEG_2:     digit = 4'd2;
         SEG_3:     digit = 4'd3;
         SEG_4:     digit = 4'd4;
         SEG_5:     digit = 4'd5;
         SEG_6:     digit = 4'd6;
         SEG_7:     digit = 4'd7;
         SEG_8:     digit = 4'd8;
         SEG_9:     digit = 4'd9;
         SEG_BLANK: begin
            digit = DIGIT_BLANK;
            blank = 1'b1;
         end
         default:   err = 1'b1;
      endcase
   end

endmodule

// File: rtl/seven_seg_scan_decoder.sv
// Reads a multiplexed seven-segment bus and reconstructs per-digit value,
// decimal point and error status once each digit has been stable long enough.
module seven_seg_scan_decoder
   import seven_seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS     = 4,
   parameter int unsigned STABLE_CYCLES  = 4,
   parameter int unsigned TIMEOUT_CYCLES = 2**20
) (
   input  logic                    clk,
   input  logic                    rst,
   input  seg_t                    seg_in,
   input  logic [0:NUM_DIGITS-1]   an_in,
   input  logic                    dp_in,
   output logic [4*NUM_DIGITS-1:0] digits_o,
   output logic [NUM_DIGITS-1:0]   valid_o,
   output logic [NUM_DIGITS-1:0]   err_o,
   output logic [NUM_DIGITS-1:0]   dp_o,
   output logic                    frame_o,
   output logic                    stale_o
);

   localparam int unsigned SampW = NUM_DIGITS + 8;
   localparam int unsigned CntW  = $clog2(STABLE_CYCLES + 1);
   localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);

   logic [SampW-1:0]        sync1_q, sync2_q, prev_q;
   logic [CntW-1:0]         cnt_q, cnt_d;
   logic [TmoW-1:0]         tmo_q;
   logic [4*NUM_DIGITS-1:0] digits_q;
   logic [NUM_DIGITS-1:0]   valid_q, err_q, dp_q, seen_q, seen_set;
   logic                    frame_q, stale_q;

   logic [0:NUM_DIGITS-1]   an_s;
   seg_t                    seg_s;
   logic                    dp_s;
   logic [NUM_DIGITS-1:0]   sel;
   logic                    legal, same, capture;
   logic [3:0]              dec_digit, cap_digit;
   logic                    dec_blank, dec_err;

   // Sample layout: {an[0..N-1], seg[0..6], dp}, an[0] in the MSB.
   assign an_s  = sync2_q[SampW-1 -: NUM_DIGITS];
   assign seg_s = sync2_q[7:1];
   assign dp_s  = sync2_q[0];

   always_comb begin
      sel = '0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         sel[i] = ~an_s[i];
      end
      legal = ($countones(sel) == 1);
   end

   assign same = (sync2_q == prev_q);

   always_comb begin
      cnt_d = cnt_q;
      if (!legal) begin
         cnt_d = '0;
      end else if (!same) begin
         cnt_d = CntW'(1);
      end else if (cnt_q != CntW'(STABLE_CYCLES)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Only the transition into saturation captures, so a held pattern fires once.
   assign capture  = legal && same && (cnt_q == CntW'(STABLE_CYCLES - 1));
   assign seen_set = seen_q | sel;
   assign cap_digit = dec_blank ? DIGIT_BLANK : dec_digit;

   seg_pattern_decode u_decode (
      .seg   (seg_s),
      .digit (dec_digit),
      .blank (dec_blank),
      .err   (dec_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q  <= '1;
         sync2_q  <= '1;
         prev_q   <= '1;
         cnt_q    <= '0;
         tmo_q    <= '0;
         digits_q <= '0;
         valid_q  <= '0;
         err_q    <= '0;
         dp_q     <= '0;
         seen_q   <= '0;
         frame_q  <= 1'b0;
         stale_q  <= 1'b0;
      end else begin
         sync1_q <= {an_in, seg_in, dp_in};
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         cnt_q   <= cnt_d;
         frame_q <= 1'b0;
         if (capture) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
               if (sel[i]) begin
                  digits_q[4*i +: 4] <= cap_digit;
                  err_q[i]           <= dec_err;
                  dp_q[i]            <= ~dp_s;
                  valid_q[i]         <= 1'b1;
               end
            end
            tmo_q   <= '0;
            stale_q <= 1'b0;
            if (&seen_set) begin
               frame_q <= 1'b1;
               seen_q  <= '0;
            end else begin
               seen_q <= seen_set;
            end
         end else if (tmo_q != TmoW'(TIMEOUT_CYCLES)) begin
            tmo_q <= tmo_q + 1'b1;
            if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
               stale_q <= 1'b1;
               valid_q <= '0;
               seen_q  <= '0;
            end
         end
      end
   end

   assign digits_o = digits_q;
   assign valid_o  = valid_q;
   assign err_o    = err_q;
   assign dp_o     = dp_q;
   assign frame_o  = frame_q;
   assign stale_o  = stale_q;

endmodule

// File: tb/tb_seven_seg_scan_decoder.sv
// Bench for seven_seg_scan_decoder: directed scenarios plus random bus traffic,
// all checked every cycle against a sample-history reference model.
module tb_seven_seg_scan_decoder;

   localparam int N = 4;
   localparam int S = 4;
   localparam int T = 64;

   localparam logic [6:0] SEG_TBL [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                           7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

   logic           clk = 1'b0;
   logic           rst;
   logic [0:6]     seg_in;
   logic [0:N-1]   an_in;
   logic           dp_in;
   logic [4*N-1:0] digits_o;
   logic [N-1:0]   valid_o, err_o, dp_o;
   logic           frame_o, stale_o;

   always #5 clk = ~clk;

   seven_seg_scan_decoder #(
      .NUM_DIGITS     (N),
      .STABLE_CYCLES  (S),
      .TIMEOUT_CYCLES (T)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .seg_in   (seg_in),
      .an_in    (an_in),
      .dp_in    (dp_in),
      .digits_o (digits_o),
      .valid_o  (valid_o),
      .err_o    (err_o),
      .dp_o     (dp_o),
      .frame_o  (frame_o),
      .stale_o  (stale_o)
   );

   int checks   = 0;
   int failures = 0;
   int frame_cnt = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference model state; a sample is {an[0..N-1], seg[0..6], dp}.
   logic [N+7:0]   m_d1, m_d2;
   logic [N+7:0]   hist [$];
   logic [4*N-1:0] m_digits;
   logic [N-1:0]   m_valid, m_err, m_dp, m_seen;
   logic           m_frame, m_stale;
   int             m_tmo;

   function automatic int digit_of(input logic [N+7:0] smp);
      int cnt = 0;
      int idx = -1;
      for (int i = 0; i < N; i++) begin
         if (!smp[N+7-i]) begin
            cnt++;
            idx = i;
         end
      end
      return (cnt == 1) ? idx : -1;
   endfunction

   function automatic logic [4:0] ref_decode(input logic [6:0] s);
      if (s == 7'h7F) return {1'b0, 4'hF};
      for (int i = 0; i < 10; i++) begin
         if (s == SEG_TBL[i]) return {1'b0, 4'(i)};
      end
      return {1'b1, 4'hE};
   endfunction

   function automatic logic [0:N-1] one_cold(input int d);
      logic [0:N-1] a = '1;
      a[d] = 1'b0;
      return a;
   endfunction

   task automatic model_edge();
      logic [N+7:0] smp;
      logic [4:0]   dec;
      bit           cap;
      int           d;
      m_frame = 1'b0;
      if (rst) begin
         m_d1 = '1; m_d2 = '1;
         hist.delete();
         m_digits = '0; m_valid = '0; m_err = '0; m_dp = '0; m_seen = '0;
         m_stale = 1'b0; m_tmo = 0;
         return;
      end
      smp  = m_d2;
      m_d2 = m_d1;
      m_d1 = {an_in, seg_in, dp_in};
      hist.push_back(smp);
      if (hist.size() > S + 1) void'(hist.pop_front());
      // Capture when the last S samples are one legal pattern not seen just before them.
      cap = 1'b0;
      d = digit_of(smp);
      if (hist.size() >= S && d >= 0) begin
         cap = 1'b1;
         for (int k = 1; k < S; k++) begin
            if (hist[hist.size()-1-k] != smp) cap = 1'b0;
         end
         if (hist.size() == S + 1 && hist[0] == smp) cap = 1'b0;
      end
      if (cap) begin
         dec = ref_decode(smp[7:1]);
         m_digits[4*d +: 4] = dec[3:0];
         m_err[d]   = dec[4];
         m_dp[d]    = ~smp[0];
         m_valid[d] = 1'b1;
         m_seen[d]  = 1'b1;
         if (&m_seen) begin
            m_frame = 1'b1;
            m_seen  = '0;
         end
         m_tmo   = 0;
         m_stale = 1'b0;
      end else if (m_tmo != T) begin
         m_tmo++;
         if (m_tmo == T) begin
            m_stale = 1'b1;
            m_valid = '0;
            m_seen  = '0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      check_eq("digits", 32'(digits_o), 32'(m_digits));
      check_eq("valid",  32'(valid_o),  32'(m_valid));
      check_eq("err",    32'(err_o),    32'(m_err));
      check_eq("dp",     32'(dp_o),     32'(m_dp));
      check_eq("frame",  32'(frame_o),  32'(m_frame));
      check_eq("stale",  32'(stale_o),  32'(m_stale));
      if (frame_o === 1'b1) frame_cnt++;
   endtask

   task automatic hold(input logic [0:N-1] an, input logic [6:0] seg, input logic dp,
                       input int n);
      an_in  = an;
      seg_in = seg;
      dp_in  = dp;
      repeat (n) step();
   endtask

   initial begin
      int lat;
      rst = 1'b1; an_in = '1; seg_in = '1; dp_in = 1'b1;
      step();
      step();
      rst = 1'b0;
      check_eq("reset_digits", 32'(digits_o), 32'h0);
      check_eq("reset_valid",  32'(valid_o),  32'h0);

      // Static digit 0 = 2, measure capture latency.
      an_in = 4'b0111; seg_in = 7'h12; dp_in = 1'b1;
      lat = 0;
      for (int e = 1; e <= 20; e++) begin
         step();
         if (lat == 0 && digits_o[3:0] == 4'd2) lat = e;
      end
      check_eq("latency", 32'(lat), 32'(S + 2));
      check_eq("static_valid", 32'(valid_o), 32'b0001);
      check_eq("static_hi", 32'(digits_o[15:4]), 32'h0);

      // Three scan sweeps showing 1,2,3,4.
      frame_cnt = 0;
      for (int sw = 0; sw < 3; sw++) begin
         for (int d = 0; d < N; d++) begin
            hold(one_cold(d), SEG_TBL[d+1], 1'b1, 8);
            hold('1, 7'h7F, 1'b1, 2);
         end
      end
      check_eq("scan_digits", 32'(digits_o), 32'h4321);
      check_eq("scan_frames", 32'(frame_cnt), 32'd3);

      // Short glitch, then two anodes active: neither may capture.
      hold(4'b0111, 7'h4F, 1'b1, 3);
      hold(4'b0011, 7'h4F, 1'b1, 10);
      check_eq("glitch_d0", 32'(digits_o[3:0]), 32'h1);
      hold(4'b1101, 7'h7E, 1'b1, 10);
      check_eq("illegal_d2", 32'(digits_o[11:8]), 32'hE);
      check_eq("illegal_err", 32'(err_o[2]), 32'h1);
      hold(4'b1101, 7'h24, 1'b1, 10);
      check_eq("five_d2", 32'(digits_o[11:8]), 32'h5);
      check_eq("five_err", 32'(err_o[2]), 32'h0);

      // Blank pattern with decimal point on digit 1.
      hold(4'b1011, 7'h7F, 1'b0, 10);
      check_eq("blank_d1", 32'(digits_o[7:4]), 32'hF);
      check_eq("blank_err", 32'(err_o[1]), 32'h0);
      check_eq("blank_dp", 32'(dp_o[1]), 32'h1);

      // Full frame, then idle long enough to go stale.
      for (int d = 0; d < N; d++) hold(one_cold(d), SEG_TBL[d+5], 1'b1, 8);
      hold('1, 7'h7F, 1'b1, T + 6);
      check_eq("stale_set", 32'(stale_o), 32'h1);
      check_eq("stale_valid", 32'(valid_o), 32'h0);
      hold(4'b1110, 7'h06, 1'b1, 10);
      check_eq("stale_clr", 32'(stale_o), 32'h0);
      check_eq("stale_revalid", 32'(valid_o), 32'b1000);

      // Reset mid-frame: the remaining two digits alone must not complete a frame.
      hold(4'b0111, 7'h01, 1'b1, 8);
      hold(4'b1011, 7'h4F, 1'b1, 8);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check_eq("midrst_digits", 32'(digits_o), 32'h0);
      check_eq("midrst_flags", 32'({valid_o, err_o, dp_o, frame_o, stale_o}), 32'h0);
      frame_cnt = 0;
      hold(4'b1101, 7'h12, 1'b1, 8);
      hold(4'b1110, 7'h06, 1'b1, 8);
      check_eq("midrst_noframe", 32'(frame_cnt), 32'h0);

      // Random bus traffic.
      for (int it = 0; it < 400; it++) begin
         logic [0:N-1] an;
         logic [6:0]   seg;
         int           r;
         r = $urandom_range(0, 99);
         if (r < 70)      an = one_cold($urandom_range(0, N-1));
         else if (r < 85) an = '1;
         else             an = 4'($urandom);
         r = $urandom_range(0, 99);
         if (r < 65)      seg = SEG_TBL[$urandom_range(0, 9)];
         else if (r < 75) seg = 7'h7F;
         else             seg = 7'($urandom);
         if ($urandom_range(0, 99) == 0) begin
            rst = 1'b1;
            step();
            rst = 1'b0;
         end
         hold(an, seg, 1'($urandom), $urandom_range(1, 10));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
